// File: rtl/muldiv_hilo_unit_if.sv
// Bundles the EX-stage HI/LO request and response signals.
interface muldiv_hilo_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             en;
  logic             resmove;
  logic             spaddr;
  logic             uns;
  logic             mf;
  logic             mf_sel;
  logic [WIDTH-1:0] srca;
  logic [WIDTH-1:0] srcb;
  logic             flush;
  logic [WIDTH-1:0] mf_result;
  logic             busy;
  logic             stall;

  modport master (
    output en, resmove, spaddr, uns, mf, mf_sel, srca, srcb, flush,
    input  mf_result, busy, stall
  );

  modport slave (
    input  en, resmove, spaddr, uns, mf, mf_sel, srca, srcb, flush,
    output mf_result, busy, stall
  );
endinterface

// File: rtl/muldiv_hilo_unit.sv
// Iterative MULT/MULTU/DIV/DIVU engine that owns HI/LO and serves moves to and from them.
module muldiv_hilo_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  muldiv_hilo_unit_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_e;

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic [WIDTH-1:0]   b_q;
  logic [WIDTH-1:0]   a_raw_q;
  logic [2*WIDTH-1:0] acc_q;
  logic               is_div_q, qneg_q, rneg_q, div0_q;

  logic               accept, move;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_sh;
  logic [WIDTH+1:0]   div_diff;
  logic [2*WIDTH-1:0] acc_d;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   hi_d, lo_d;

  assign accept = (state_q == S_IDLE) & bus.en & bus.resmove & ~bus.flush;
  assign move   = (state_q == S_IDLE) & bus.en & ~bus.resmove & ~bus.flush;

  assign bus.busy      = (state_q != S_IDLE);
  assign bus.stall     = bus.busy & (bus.mf | bus.en);
  assign bus.mf_result = bus.mf_sel ? lo_q : hi_q;

  always_comb begin
    mag_a = (~bus.uns & bus.srca[WIDTH-1]) ? -bus.srca : bus.srca;
    mag_b = (~bus.uns & bus.srcb[WIDTH-1]) ? -bus.srcb : bus.srcb;

    // Multiply shifts the accumulator right, dividing shifts it left; both
    // share acc_q with the operand that is consumed bitwise in its low half.
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
    div_sh   = acc_q[2*WIDTH-1:WIDTH-1];
    div_diff = {1'b0, div_sh} - {2'b00, b_q};

    acc_d = acc_q;
    if (is_div_q) begin
      if (div_diff[WIDTH+1])
        acc_d = {div_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
      else
        acc_d = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end else begin
      acc_d = {mul_sum, acc_q[WIDTH-1:1]};
    end

    prod = qneg_q ? -acc_q : acc_q;
    hi_d = prod[2*WIDTH-1:WIDTH];
    lo_d = prod[WIDTH-1:0];
    if (is_div_q) begin
      if (div0_q) begin
        hi_d = a_raw_q;
        lo_d = '1;
      end else begin
        hi_d = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
        lo_d = qneg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      b_q      <= '0;
      a_raw_q  <= '0;
      acc_q    <= '0;
      is_div_q <= 1'b0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      div0_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            is_div_q <= bus.spaddr;
            a_raw_q  <= bus.srca;
            b_q      <= bus.spaddr ? mag_b : mag_a;
            acc_q    <= {{WIDTH{1'b0}}, (bus.spaddr ? mag_a : mag_b)};
            qneg_q   <= ~bus.uns & (bus.srca[WIDTH-1] ^ bus.srcb[WIDTH-1]);
            rneg_q   <= ~bus.uns & bus.srca[WIDTH-1];
            div0_q   <= (bus.srcb == '0);
            cnt_q    <= '0;
            state_q  <= S_RUN;
          end else if (move) begin
            if (bus.spaddr) lo_q <= bus.srca;
            else            hi_q <= bus.srca;
          end
        end
        S_RUN: begin
          if (bus.flush) begin
            state_q <= S_IDLE;
          end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CNT_W'(WIDTH - 1)) state_q <= S_FIX;
          end
        end
        S_FIX: begin
          if (!bus.flush) begin
            hi_q <= hi_d;
            lo_q <= lo_d;
          end
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_hilo_unit.sv
// Directed scoreboard bench for the HI/LO mul/div unit.
module tb_muldiv_hilo_unit;

  logic clk;
  logic reset;

  muldiv_hilo_unit_if #(.WIDTH(32)) bus ();

  muldiv_hilo_unit #(.WIDTH(32), .CNT_W(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t sb[$];
  int   total  = 0;
  int   passed = 0;
  int   fails  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h required %h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.en = 1'b0; bus.resmove = 1'b0; bus.spaddr = 1'b0; bus.uns = 1'b0;
    bus.mf = 1'b0; bus.mf_sel = 1'b0; bus.srca = '0; bus.srcb = '0; bus.flush = 1'b0;
  endtask

  task automatic read_hilo(output logic [31:0] hi, output logic [31:0] lo);
    bus.mf = 1'b1; bus.mf_sel = 1'b0; #1;
    hi = bus.mf_result;
    bus.mf_sel = 1'b1; #1;
    lo = bus.mf_result;
    bus.mf = 1'b0; bus.mf_sel = 1'b0;
  endtask

  task automatic pop_check();
    exp_t e;
    logic [31:0] hi, lo;
    if (sb.size() == 0) begin
      total++; fails++;
      $error("FAIL scoreboard_empty: observed 0 entries required 1");
    end else begin
      e = sb.pop_front();
      read_hilo(hi, lo);
      check({e.tag, "_hi"}, hi, e.hi);
      check({e.tag, "_lo"}, lo, e.lo);
    end
  endtask

  // Returns with inputs applied at #1 after the accepting edge.
  task automatic start_op(input logic spaddr, input logic uns,
                          input logic [31:0] a, input logic [31:0] b);
    @(posedge clk); #1;
    bus.en = 1'b1; bus.resmove = 1'b1; bus.spaddr = spaddr; bus.uns = uns;
    bus.srca = a; bus.srcb = b;
    @(posedge clk); #1;
    bus.en = 1'b0; bus.resmove = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (bus.busy && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic run_op(input string tag, input logic spaddr, input logic uns,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ehi, input logic [31:0] elo);
    int n;
    sb.push_back('{tag, ehi, elo});
    start_op(spaddr, uns, a, b);
    check({tag, "_busy"}, 32'(bus.busy), 32'd1);
    wait_idle(n);
    check({tag, "_latency"}, 32'(n), 32'd33);
    pop_check();
  endtask

  initial begin
    int n;
    logic [31:0] cur_hi, cur_lo;
    idle_inputs();
    reset = 1'b0;
    #12;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_stall", 32'(bus.stall), 32'd0);
    sb.push_back('{"rst", 32'h0, 32'h0});
    pop_check();
    @(posedge clk); #1;
    reset = 1'b1;

    run_op("mult",  1'b0, 1'b0, 32'hFFFFFFFE, 32'h3, 32'hFFFFFFFF, 32'hFFFFFFFA);
    run_op("multu", 1'b0, 1'b1, 32'hFFFFFFFE, 32'h3, 32'h00000002, 32'hFFFFFFFA);
    run_op("div",   1'b1, 1'b0, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("divu",  1'b1, 1'b1, 32'd100,      32'd7, 32'd2,        32'd14);
    run_op("divu0", 1'b1, 1'b1, 32'd5,        32'd0, 32'd5,        32'hFFFFFFFF);
    run_op("div0",  1'b1, 1'b0, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, 32'hFFFFFFFF);
    run_op("divov", 1'b1, 1'b0, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000);
    run_op("mulneg",1'b0, 1'b0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0);

    // MFLO right behind an in-flight MULT: held for the whole operation.
    sb.push_back('{"mflo_mult", 32'h0, 32'd42});
    start_op(1'b0, 1'b0, 32'd6, 32'd7);
    bus.mf = 1'b1; bus.mf_sel = 1'b1;
    check("mflo_stall_first", 32'(bus.stall), 32'd1);
    n = 0;
    while (bus.stall && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check("mflo_stall_cycles", 32'(n), 32'd33);
    check("mflo_result", bus.mf_result, 32'd42);
    bus.mf = 1'b0; bus.mf_sel = 1'b0;
    pop_check();

    // MTHI while idle.
    sb.push_back('{"mthi", 32'h1234, 32'd42});
    @(posedge clk); #1;
    bus.en = 1'b1; bus.resmove = 1'b0; bus.spaddr = 1'b0; bus.srca = 32'h1234;
    @(posedge clk); #1;
    bus.en = 1'b0;
    check("mthi_busy", 32'(bus.busy), 32'd0);
    pop_check();

    // MTLO issued behind a DIV: held, then applied after the DIV result.
    sb.push_back('{"mtlo_after_div", 32'd2, 32'hCAFE});
    start_op(1'b1, 1'b1, 32'd100, 32'd7);
    bus.en = 1'b1; bus.resmove = 1'b0; bus.spaddr = 1'b1; bus.srca = 32'hCAFE;
    check("mtlo_stall", 32'(bus.stall), 32'd1);
    wait_idle(n);
    check("mtlo_wait", 32'(n), 32'd33);
    @(posedge clk); #1;
    bus.en = 1'b0;
    pop_check();

    // Flush mid-DIV: no HI/LO update.
    read_hilo(cur_hi, cur_lo);
    sb.push_back('{"flush", 32'd2, 32'hCAFE});
    start_op(1'b1, 1'b0, 32'd1000, 32'd3);
    repeat (9) @(posedge clk);
    #1 bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    check("flush_busy", 32'(bus.busy), 32'd0);
    repeat (40) @(posedge clk);
    #1;
    pop_check();

    // Reset mid-DIV: immediate clear.
    start_op(1'b1, 1'b0, 32'd1000, 32'd3);
    repeat (10) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check("rstmid_busy", 32'(bus.busy), 32'd0);
    check("rstmid_stall", 32'(bus.stall), 32'd0);
    sb.push_back('{"rstmid", 32'h0, 32'h0});
    pop_check();
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    sb.push_back('{"rstmid_after", 32'h0, 32'h0});
    pop_check();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/muldiv_hilo_unit.md
Name: muldiv_hilo_unit

Overview:
- Execute-stage HI/LO unit, downstream of the main decoder.
- Consumes the decoder's spregwrite, mf, resmove and spaddr outputs, plus funct[0], to run MULT/MULTU/DIV/DIVU iteratively and to service MTHI/MTLO/MFHI/MFLO.
- Owns the HI and LO architectural registers.
- Raises stall to the hazard unit while a mul/div is in flight and a dependent HI/LO access arrives.

Parameters:
- WIDTH, 32, operand and HI/LO width
- CNT_W, 5, iteration counter width; must satisfy 2^CNT_W = WIDTH

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- en  in  1  decoder spregwrite in EX: HI/LO-writing instruction valid
- resmove  in  1  funct[3]: 1 = mult/div, 0 = move-to (MTHI/MTLO)
- spaddr  in  1  funct[1]: with resmove=1, 0 = mult and 1 = div; with resmove=0, 0 = MTHI and 1 = MTLO
- uns  in  1  funct[0]: 1 = unsigned (MULTU/DIVU); ignored for moves
- mf  in  1  decoder mf in EX: MFHI/MFLO valid
- mf_sel  in  1  funct[1] of the mf instruction: 0 = HI, 1 = LO
- srca  in  WIDTH  rs value, forwarded (multiplicand/dividend, or move source)
- srcb  in  WIDTH  rt value, forwarded (multiplier/divisor)
- flush  in  1  squash the EX instruction and abort any in-flight operation
- mf_result  out  WIDTH  HI or LO per mf_sel (combinational)
- busy  out  1  operation in flight
- stall  out  1  hold IF/ID/EX and bubble MEM

Behaviour:
- Reset (reset=0, asynchronous): HI=0, LO=0, state=IDLE, counter=0. Outputs: busy=0, stall=0, mf_result=0.
- States: IDLE, RUN, FIX. busy = (state != IDLE).
- Accept condition: IDLE & en & resmove & ~flush.
  - Latch operands as magnitudes: signed ops take two's-complement absolute values; unsigned ops pass through.
  - Record result signs: quotient sign = sa^sb; remainder sign = sa.
  - counter=0; state -> RUN.
- RUN, one iteration per cycle:
  - Multiply: radix-2 shift-add into a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract, yielding quotient and remainder.
  - After the iteration with counter = WIDTH-1: state -> FIX.
- FIX: apply sign correction, write {HI,LO}, state -> IDLE.
  - Multiply: {HI,LO} = 64-bit product.
  - Divide: LO = quotient, HI = remainder.
- Latency: accept at edge E0; HI/LO updated at edge E(WIDTH+1) = E33. An MFHI/MFLO in EX during the cycle after E33 sees the new value.
- Divide by zero: no exception. HI = srca, LO = 0xFFFFFFFF, for both signed and unsigned.
- Signed overflow (0x80000000 / 0xFFFFFFFF): LO = 0x80000000, HI = 0.
- Move-to: IDLE & en & ~resmove & ~flush writes srca to HI (spaddr=0) or LO (spaddr=1) at the next edge. One-cycle op; busy stays 0.
- Stall rule: stall = busy & (mf | en).
  - Stalled instructions are held, not accepted.
  - A held instruction is accepted or read in the cycle after state returns to IDLE.
  - stall = 0 whenever busy = 0.
- mf_result is always driven from current HI/LO, including while stalled. The consumer ignores it while stall = 1.
- flush:
  - In IDLE: blocks acceptance; no HI/LO change.
  - In RUN/FIX: next state IDLE; HI/LO retain pre-operation values; busy = 0 in the following cycle.
- Reset mid-operation: immediate return to IDLE with HI=LO=0. No partial write.
- Back-to-back mul/div ops: the second stalls for the full first operation, then starts. No overlap.

Test Plan:
- MULT 0xFFFFFFFE x 0x00000003: next-edge busy=1, 33 cycles to completion -> HI=0xFFFFFFFF, LO=0xFFFFFFFA. MULTU with the same operands -> HI=0x00000002, LO=0xFFFFFFFA.
- DIV -7 / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 100 / 7 -> LO=14, HI=2.
- DIVU 5 / 0 -> LO=0xFFFFFFFF, HI=5. DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- MFLO issued one cycle after MULT 6 x 7 accept: stall=1 for 33 cycles, then stall=0 and mf_result=42 in the same cycle.
- MTHI 0x1234 while idle -> HI=0x1234 next edge, busy stays 0. MTLO during a busy DIV -> stalls; LO then equals the MTLO value (the later write wins).
- Start DIV, assert flush at cycle 10 -> busy=0 next cycle, HI/LO unchanged. Repeat with reset pulled low at cycle 10 -> HI=LO=0 immediately and busy=0.
